// File: rtl/button_autorepeat_pkg.sv
// Shared timing defaults, FSM state encoding and a small sizing helper
// for the push-button conditioner.
package button_autorepeat_pkg;

    // Timing defaults for a 10 MHz system clock.
    localparam int DEBOUNCE_10MS = 100_000;
    localparam int REPEAT_500MS  = 5_000_000;
    localparam int REPEAT_100MS  = 1_000_000;

    // Conditioner FSM states (3-bit binary).
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD_DELAY  = 3'd2,
        ST_HELD_REPEAT = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } state_t;

    // Largest of three timing values; sizes the shared counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_autorepeat_if.sv
// Button-side signal bundle: the raw pin and repeat enable in, the
// conditioned pulses and level out.
interface button_autorepeat_if;
    logic button_in;
    logic repeat_en;
    logic one_shot_pulse;
    logic pressed;
    logic release_pulse;

    // Driver of the raw button and consumer of the conditioned outputs.
    modport master (
        output button_in,
        output repeat_en,
        input  one_shot_pulse,
        input  pressed,
        input  release_pulse
    );

    // The conditioner itself.
    modport slave (
        input  button_in,
        input  repeat_en,
        output one_shot_pulse,
        output pressed,
        output release_pulse
    );
endinterface

// File: rtl/button_autorepeat_sync_chain.sv
// Multi-flop synchroniser for one asynchronous input, cleared by a
// synchronous reset so a held button is seen as a fresh edge afterwards.
module btn_sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw pin through the chain; bit 0 is the metastable stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_autorepeat.sv
// Per-button conditioner: synchronise, debounce press and release, emit a
// one-cycle pulse on press and optional auto-repeat pulses while held.
module button_autorepeat
    import button_autorepeat_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS,
    parameter int REPEAT_DELAY    = REPEAT_500MS,
    parameter int REPEAT_PERIOD   = REPEAT_100MS
) (
    input  logic                clk,
    input  logic                reset,
    button_autorepeat_if.slave  btn
);

    localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic             btn_s;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;
    logic             pressed_q, pressed_d;
    logic             rel_q, rel_d;

    btn_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.button_in),
        .q     (btn_s)
    );

    // State, shared counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            pulse_q   <= 1'b0;
            pressed_q <= 1'b0;
            rel_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pulse_q   <= pulse_d;
            pressed_q <= pressed_d;
            rel_q     <= rel_d;
        end
    end

    // Next-state, counter and output decode; a dropping btn_s always wins
    // over a repeat that happens to be due in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pulse_d   = 1'b0;
        pressed_d = pressed_q;
        rel_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_HELD_DELAY;
                    cnt_d     = '0;
                    pulse_d   = 1'b1;
                    pressed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD_DELAY: begin
                if (!btn_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = '0;
                end else if (btn.repeat_en && cnt_q == DLY_LAST) begin
                    state_d = ST_HELD_REPEAT;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else if (cnt_q != DLY_LAST) begin
                    // Saturates here while repeat is disabled.
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_DEB_RELEASE;
                    cnt_d   = '0;
                end else if (!btn.repeat_en) begin
                    state_d = ST_HELD_DELAY;
                    cnt_d   = '0;
                end else if (cnt_q == PER_LAST) begin
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DEB_RELEASE: begin
                if (btn_s) begin
                    // Release bounce: stay held and restart the repeat delay.
                    state_d = ST_HELD_DELAY;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                    rel_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn.one_shot_pulse = pulse_q;
    assign btn.pressed        = pressed_q;
    assign btn.release_pulse  = rel_q;

endmodule

// File: tb/tb_button_autorepeat.sv
// Directed bench for button_autorepeat with short timing parameters
// (debounce 4, repeat delay 10, repeat period 3). Edge numbers in the
// step loops count from the first edge that samples the new input level.
module tb_button_autorepeat;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    button_autorepeat_if bif ();

    button_autorepeat #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input int e,
                              input logic ep, input logic epr, input logic erel);
        check($sformatf("%s[%0d].one_shot_pulse", tag, e), bif.one_shot_pulse, ep);
        check($sformatf("%s[%0d].pressed", tag, e), bif.pressed, epr);
        check($sformatf("%s[%0d].release_pulse", tag, e), bif.release_pulse, erel);
    endtask

    // Advance one active edge, then sample away from it.
    task automatic step(input string tag, input int e,
                        input logic ep, input logic epr, input logic erel);
        @(posedge clk);
        #1;
        check_outs(tag, e, ep, epr, erel);
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset         = 1'b1;
        bif.button_in = 1'b0;
        bif.repeat_en = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) step("idle", i, 1'b0, 1'b0, 1'b0);

        // Press without repeat: single pulse after edge 7
        bif.button_in = 1'b1;
        for (int e = 1; e <= 30; e++)
            step("press_norep", e, e == 7, e >= 7, 1'b0);

        // Release: release pulse after edge 7, pressed drops with it
        bif.button_in = 1'b0;
        for (int e = 1; e <= 10; e++)
            step("release_norep", e, 1'b0, e < 7, e == 7);

        // Press bounce: never accepted
        bif.button_in = 1'b1;
        step("bounce", 1, 1'b0, 1'b0, 1'b0);
        step("bounce", 2, 1'b0, 1'b0, 1'b0);
        bif.button_in = 1'b0;
        step("bounce", 3, 1'b0, 1'b0, 1'b0);
        step("bounce", 4, 1'b0, 1'b0, 1'b0);
        bif.button_in = 1'b1;
        step("bounce", 5, 1'b0, 1'b0, 1'b0);
        step("bounce", 6, 1'b0, 1'b0, 1'b0);
        bif.button_in = 1'b0;
        for (int e = 7; e <= 16; e++) step("bounce", e, 1'b0, 1'b0, 1'b0);

        // Auto-repeat: pulses at 7, 17, then every 3 edges
        bif.repeat_en = 1'b1;
        bif.button_in = 1'b1;
        for (int e = 1; e <= 38; e++)
            step("repeat", e, (e == 7) || (e >= 17 && (e - 17) % 3 == 0), e >= 7, 1'b0);

        // Release glitch of 2 cycles; the repeat due at edge 3 is dropped,
        // repeat delay restarts once btn_s is back high
        bif.button_in = 1'b0;
        step("glitch", 1, 1'b0, 1'b1, 1'b0);
        step("glitch", 2, 1'b0, 1'b1, 1'b0);
        bif.button_in = 1'b1;
        for (int e = 3; e <= 21; e++)
            step("glitch", e, (e == 15) || (e == 18) || (e == 21), 1'b1, 1'b0);

        // Release from repeat; the repeat due at edge 3 loses to the release
        bif.button_in = 1'b0;
        for (int e = 1; e <= 10; e++)
            step("release_rep", e, 1'b0, e < 7, e == 7);

        // Reset while in the repeat phase with the button held
        bif.button_in = 1'b1;
        for (int e = 1; e <= 18; e++)
            step("pre_reset", e, (e == 7) || (e == 17), e >= 7, 1'b0);
        reset = 1'b1;
        step("mid_reset", 0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 18; e++)
            step("post_reset", e, (e == 7) || (e == 17), e >= 7, 1'b0);

        // Disabling repeat mid-hold stops further pulses
        bif.repeat_en = 1'b0;
        for (int e = 1; e <= 15; e++)
            step("rep_off", e, 1'b0, 1'b1, 1'b0);

        // Final release from the saturated delay phase
        bif.button_in = 1'b0;
        for (int e = 1; e <= 10; e++)
            step("release_final", e, 1'b0, e < 7, e == 7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
